heart_rate_ctrl: RTL
====================

// Module: heart_rate_ctrl
// PURPOSE
//  Sequencer for the external beat counter (clr/enb/q interface) in the health monitor.
//  Runs back-to-back fixed-length measurement windows and clears/enables the counter.
//  Converts each window's beat count to beats-per-minute and raises lo/hi rate alarms.
//  Sits between the synchronised sensor pulse and the display/alarm logic.
// PARAMETERS
//  TICK_CYCLES  100_000_000  clk cycles per 1 s tick
//  WINDOW_S     15           window length in seconds; must divide 60 (MULT = 60/WINDOW_S)
//  CNT_W        8            width of external counter q
//  BPM_W        10           width of bpm output
//  BPM_LO       40           alarm_lo threshold (bpm < BPM_LO)
//  BPM_HI       180          alarm_hi threshold (bpm > BPM_HI)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      1-cycle request: begin continuous measurement
//  stop       in   1      1-cycle request: abort and return to IDLE
//  pulse_in   in   1      beat signal, already synchronised to clk
//  cnt_q      in   CNT_W  current value of external counter
//  cnt_clr    out  1      counter synchronous clear
//  cnt_enb    out  1      counter increment enable
//  bpm        out  BPM_W  last result
//  bpm_valid  out  1      1-cycle strobe: new bpm/alarms
//  alarm_lo   out  1      last bpm < BPM_LO (held)
//  alarm_hi   out  1      last bpm > BPM_HI or saturated (held)
//  busy       out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt_clr=1, cnt_enb=0, bpm=0, bpm_valid=0, alarms=0, busy=0,
//  timers=0, sat=0, edge regs=0.
//  FSM: IDLE -start-> CLEAR -> COUNT -(window elapsed)-> LATCH -> CLEAR -> ...
//   IDLE : cnt_clr=1, counter held at 0. start is ignored in every other state.
//   CLEAR: exactly 1 cycle, cnt_clr=1, window timers and sat cleared.
//   COUNT: exactly WINDOW_S*TICK_CYCLES cycles, cnt_clr=0.
//   LATCH: 1 cycle, cnt_enb=0.
//    - Capture cnt_q.
//    - Compute bpm = cnt_q*MULT. Saturate to 2^BPM_W-1 if the product overflows or sat=1.
//   Result regs (bpm, alarms) update on the LATCH->CLEAR edge.
//   bpm_valid=1 during the following CLEAR cycle only.
//  stop (any non-IDLE state) -> IDLE next cycle.
//   - No bpm_valid.
//   - bpm/alarms keep their previous values.
//   - start and stop in the same cycle: stop wins.
//  Edge detect: p1 <= pulse_in, p2 <= p1, rise = p1 & ~p2.
//   cnt_enb = (state==COUNT) & rise & (cnt_q != all-ones). It is 1 cycle wide per rising edge.
//   Latency: pulse_in high at edge k -> cnt_enb high in cycle k+1 -> cnt_q increments at edge k+2.
//   cnt_enb in the last COUNT cycle is counted (cnt_q is valid in LATCH).
//   Edges whose rise falls in LATCH/CLEAR/IDLE are dropped.
//   A level held high counts once.
//  Saturation: if rise occurs in COUNT while cnt_q == all-ones, set sat.
//   The counter is not enabled, so it never wraps.
//  Alarms (updated with bpm): alarm_lo = bpm < BPM_LO; alarm_hi = bpm > BPM_HI | sat.
//  Timers: 1 s prescaler 0..TICK_CYCLES-1 and second counter 0..WINDOW_S-1. Both are active only in COUNT.
// TESTING (TICK_CYCLES=10, WINDOW_S=15 -> COUNT=150 cycles, MULT=4)
//  1. rst mid-COUNT -> same cycle: IDLE outputs, cnt_clr=1, cnt_enb=0, bpm=0, busy=0.
//  2. start, 18 pulses in window -> LATCH 152 cycles after start.
//     bpm=72 with bpm_valid 1 cycle, no alarms, next window starts.
//  3. 5 pulses -> bpm=20, alarm_lo=1.
//     Next window 50 pulses -> bpm=200, alarm_hi=1, alarm_lo=0.
//  4. pulse_in high for whole window -> bpm=4.
//     Edge with cnt_enb in last COUNT cycle is counted; edge during LATCH is not.
//  5. 260 pulses (CNT_W=8) -> cnt_q stops at 255, bpm=1023, alarm_hi=1.
//  6. stop at cycle 80 of COUNT -> IDLE next cycle, no bpm_valid, bpm unchanged.
//     start during COUNT is ignored.

Source files
------------

// File: rtl/heart_rate_ctrl.sv
`timescale 1ns/1ps
// heart_rate_ctrl: sequences the external beat counter through back-to-back measurement
// windows, converts each window's beat count to beats-per-minute and raises rate alarms.
module heart_rate_ctrl #(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned WINDOW_S    = 15,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned BPM_W       = 10,
  parameter int unsigned BPM_LO      = 40,
  parameter int unsigned BPM_HI      = 180
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pulse_in,
  input  logic [CNT_W-1:0] i_cnt_q,
  output logic             o_cnt_clr,
  output logic             o_cnt_enb,
  output logic [BPM_W-1:0] o_bpm,
  output logic             o_bpm_valid,
  output logic             o_alarm_lo,
  output logic             o_alarm_hi,
  output logic             o_busy
);

  localparam int unsigned MULT    = 60 / WINDOW_S;
  localparam int unsigned TICK_W  = $clog2(TICK_CYCLES + 1);
  localparam int unsigned SEC_W   = $clog2(WINDOW_S + 1);
  localparam int unsigned BPM_MAX = (1 << BPM_W) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StCount,
    StLatch
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic [SEC_W-1:0]  r_sec;
  logic              r_sat;
  logic              r_p1;
  logic              r_p2;
  logic [BPM_W-1:0]  r_bpm;
  logic              r_bpm_valid;
  logic              r_alarm_lo;
  logic              r_alarm_hi;

  logic              w_rise;
  logic              w_cnt_full;
  logic              w_tick_last;
  logic              w_sec_last;
  logic [31:0]       w_prod;
  logic              w_ovf;
  logic [BPM_W-1:0]  w_bpm_next;
  logic              w_lo_next;
  logic              w_hi_next;

  assign w_rise      = r_p1 & ~r_p2;
  // The counter is never enabled at all-ones, so it cannot wrap.
  assign w_cnt_full  = (i_cnt_q == {CNT_W{1'b1}});
  assign w_tick_last = (r_tick == TICK_W'(TICK_CYCLES - 1));
  assign w_sec_last  = (r_sec == SEC_W'(WINDOW_S - 1));

  // Result is computed from cnt_q during LATCH and registered on the LATCH->CLEAR edge.
  assign w_prod     = 32'(i_cnt_q) * MULT;
  assign w_ovf      = r_sat | (w_prod > BPM_MAX);
  assign w_bpm_next = w_ovf ? {BPM_W{1'b1}} : w_prod[BPM_W-1:0];
  assign w_lo_next  = (32'(w_bpm_next) < BPM_LO);
  assign w_hi_next  = (32'(w_bpm_next) > BPM_HI) | r_sat;

  assign o_cnt_clr   = (r_state == StIdle) | (r_state == StClear);
  assign o_cnt_enb   = (r_state == StCount) & w_rise & ~w_cnt_full;
  assign o_busy      = (r_state != StIdle);
  assign o_bpm       = r_bpm;
  assign o_bpm_valid = r_bpm_valid;
  assign o_alarm_lo  = r_alarm_lo;
  assign o_alarm_hi  = r_alarm_hi;

  // Two-stage history of the synchronised pulse for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p1 <= 1'b0;
      r_p2 <= 1'b0;
    end else begin
      r_p1 <= i_pulse_in;
      r_p2 <= r_p1;
    end
  end

  // Window sequencer: state, window timers, saturation flag and registered results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_tick      <= '0;
      r_sec       <= '0;
      r_sat       <= 1'b0;
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
      r_alarm_lo  <= 1'b0;
      r_alarm_hi  <= 1'b0;
    end else begin
      r_bpm_valid <= 1'b0;
      if (i_stop && (r_state != StIdle)) begin
        // Abort keeps the previous result and suppresses the strobe.
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start && !i_stop) r_state <= StClear;
          end
          StClear: begin
            r_tick  <= '0;
            r_sec   <= '0;
            r_sat   <= 1'b0;
            r_state <= StCount;
          end
          StCount: begin
            if (w_rise && w_cnt_full) r_sat <= 1'b1;
            if (w_tick_last) begin
              r_tick <= '0;
              if (w_sec_last) begin
                r_sec   <= '0;
                r_state <= StLatch;
              end else begin
                r_sec <= r_sec + SEC_W'(1);
              end
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
          StLatch: begin
            r_bpm       <= w_bpm_next;
            r_alarm_lo  <= w_lo_next;
            r_alarm_hi  <= w_hi_next;
            r_bpm_valid <= 1'b1;
            r_state     <= StClear;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule
